// File: rtl/steer_controller.sv
// Line-following steering: centroid error -> P(D) correction -> two glitch-free PWMs.
// Build option: define STEER_DERIV_EN to add the KD*d derivative term.
module steer_controller #(
  parameter int IMG_W        = 640,
  parameter int PWM_PERIOD   = 1000,
  parameter int BASE_DUTY    = 600,
  parameter int SEARCH_DUTY  = 400,
  parameter int KP           = 2,
  parameter int KD           = 1,
  parameter int GAIN_SHIFT   = 1,
  parameter int LOST_TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd,
  input  logic [9:0] centroid_x,
  input  logic       line_valid,
  input  logic       line_lost,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic [9:0] duty_l,
  output logic [9:0] duty_r,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    SEARCH = 2'd2,
    STOP   = 2'd3
  } st_t;

  localparam int LW = $clog2(LOST_TIMEOUT + 1);

  st_t st_q, st_d;
  logic [LW-1:0] lost_q, lost_d, lost_inc;
  logic signed [10:0] err;
  logic trk_upd;

  assign err = $signed({1'b0, centroid_x}) - $signed(11'(IMG_W / 2));
  assign lost_inc = (lost_q >= LW'(LOST_TIMEOUT)) ? lost_q : lost_q + 1'b1;

  always_comb begin
    st_d   = st_q;
    lost_d = lost_q;
    if (upd) begin
      unique case (st_q)
        IDLE: begin
          if (line_valid && !line_lost) st_d = TRACK;
        end
        TRACK: begin
          if (line_lost) begin
            st_d   = SEARCH;
            lost_d = LW'(1);
          end
        end
        SEARCH, STOP: begin
          if (line_lost) begin
            lost_d = lost_inc;
            if (lost_inc >= LW'(LOST_TIMEOUT)) st_d = STOP;
          end else if (line_valid) begin
            st_d   = TRACK;
            lost_d = '0;
          end
        end
      endcase
    end
  end

  assign trk_upd = upd && line_valid && !line_lost && (st_d == TRACK);

  // Stage 1: FSM, error capture, sign of last tracked error
  logic               v1, neg_q;
  st_t                st1;
  logic signed [10:0] err1;
  logic signed [11:0] d1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= IDLE;
      lost_q <= '0;
      v1     <= 1'b0;
      st1    <= IDLE;
      err1   <= '0;
      neg_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      lost_q <= lost_d;
      v1     <= upd && (line_valid || line_lost);
      st1    <= st_d;
      if (trk_upd) begin
        err1  <= err;
        neg_q <= err[10];
      end
    end
  end

`ifdef STEER_DERIV_EN
  logic signed [10:0] err_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_prev <= '0;
      d1       <= '0;
    end else if (trk_upd) begin
      err_prev <= err;
      d1       <= (st_q == TRACK) ? 12'(err) - 12'(err_prev) : '0;
    end
  end
`else
  assign d1 = '0;
`endif

  // Stage 2: correction, saturation, target registers
  logic signed [23:0] corr, sum_l, sum_r;
  logic [9:0] tgt_l, tgt_r;

  always_comb begin
`ifdef STEER_DERIV_EN
    corr = (signed'(24'(KP)) * 24'(err1)
          + signed'(24'(KD)) * 24'(d1)) >>> GAIN_SHIFT;
`else
    corr = (signed'(24'(KP)) * 24'(err1)) >>> GAIN_SHIFT;
`endif
    sum_l = signed'(24'(BASE_DUTY)) + corr;
    sum_r = signed'(24'(BASE_DUTY)) - corr;
  end

  function automatic logic [9:0] sat(input logic signed [23:0] x);
    if (x < 0) return '0;
    if (x > signed'(24'(PWM_PERIOD))) return 10'(PWM_PERIOD);
    return x[9:0];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tgt_l <= '0;
      tgt_r <= '0;
    end else if (v1) begin
      unique case (st1)
        TRACK: begin
          tgt_l <= sat(sum_l);
          tgt_r <= sat(sum_r);
        end
        SEARCH: begin
          tgt_l <= neg_q ? '0 : 10'(SEARCH_DUTY);
          tgt_r <= neg_q ? 10'(SEARCH_DUTY) : '0;
        end
        default: begin
          tgt_l <= '0;
          tgt_r <= '0;
        end
      endcase
    end
  end

  // PWM: duty only reloads at the wrap so a period is never cut short
  logic [9:0] cnt;
  logic       wrap;

  assign wrap = (cnt == 10'(PWM_PERIOD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      duty_l <= '0;
      duty_r <= '0;
      pwm_l  <= 1'b0;
      pwm_r  <= 1'b0;
    end else begin
      cnt   <= wrap ? '0 : cnt + 1'b1;
      pwm_l <= cnt < duty_l;
      pwm_r <= cnt < duty_r;
      if (wrap) begin
        duty_l <= tgt_l;
        duty_r <= tgt_r;
      end
    end
  end

  assign state = st_q;

endmodule

// File: doc/steer_controller.md
STEER_CONTROLLER -- requirements
Module: steer_controller

Interface
REQ-001 Parameter IMG_W, 640, image width in pixels; the set-point is IMG_W/2.
REQ-002 Parameter PWM_PERIOD, 1000, PWM period in clk cycles.
REQ-003 Parameters BASE_DUTY 600, SEARCH_DUTY 400, KP 2, KD 1, GAIN_SHIFT 1, LOST_TIMEOUT 30; duties are in clk cycles.
REQ-004 clk  in  1  pixel/video clock, the only clock.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 upd  in  1  one-cycle pulse, one per frame, qualifying centroid_x, line_valid and line_lost.
REQ-007 centroid_x  in  10  line centroid column, 0..IMG_W-1.
REQ-008 line_valid  in  1  line detected in the region of interest this frame.
REQ-009 line_lost  in  1  no line found this frame.
REQ-010 pwm_l, pwm_r  out  1 each  left and right motor PWM.
REQ-011 duty_l, duty_r  out  10 each  active duty values, for debug and LEDs.
REQ-012 state  out  2  IDLE=0, TRACK=1, SEARCH=2, STOP=3.

Function
REQ-013 Error: err = centroid_x - IMG_W/2, as an 11-bit signed value.
REQ-014 Derivative: d = err - err_prev, 12-bit signed; err_prev is loaded with err on every TRACK update.
REQ-015 On entry to TRACK from any other state, err_prev SHALL be set to the current err, so d=0.
REQ-016 Correction: corr = (KP*err + KD*d) >>> GAIN_SHIFT, computed at ≥20-bit signed width.
REQ-017 In TRACK: target_l = BASE_DUTY+corr and target_r = BASE_DUTY-corr, each saturated to [0, PWM_PERIOD].
REQ-018 target_l and target_r SHALL be registered exactly 2 clk cycles after the upd pulse.
REQ-019 PWM counter runs 0..PWM_PERIOD-1 and wraps.
REQ-020 Active duty (duty_l/duty_r) SHALL load from the targets only on the wrap cycle (count PWM_PERIOD-1 -> 0); no mid-period glitch.
REQ-021 pwm_x = (count < duty_x), registered; duty 0 gives constant low, duty PWM_PERIOD gives constant high.
REQ-022 FSM is evaluated only on cycles where upd=1; it holds otherwise.
REQ-023 IDLE -> TRACK on line_valid; IDLE ignores line_lost; IDLE targets are 0/0.
REQ-024 TRACK -> SEARCH on line_lost; a lost counter is set to 1 on this transition.
REQ-025 SEARCH targets: if the last err ≥ 0, left=SEARCH_DUTY and right=0; otherwise left=0 and right=SEARCH_DUTY.
REQ-026 SEARCH: each lost update increments the counter; on reaching LOST_TIMEOUT -> STOP with targets 0/0.
REQ-027 SEARCH or STOP -> TRACK on line_valid; the lost counter clears.
REQ-028 If line_valid and line_lost are both 1 in one update, line_lost wins.
REQ-029 If both are 0, the update is ignored: state, counter, err_prev and targets are unchanged.
REQ-030 The lost counter saturates at LOST_TIMEOUT and never wraps.

Reset
REQ-031 Reset SHALL force IDLE, PWM count 0, duty_l=duty_r=0, targets 0, err_prev 0, lost counter 0, and pwm_l=pwm_r=0, all asynchronously.
REQ-032 Assertion mid-period drives the outputs low immediately.
REQ-033 After release, the first PWM period starts at count 0.

Configuration
REQ-034 With STEER_DERIV_EN defined, the KD*d term is included.
REQ-035 Without STEER_DERIV_EN, corr = (KP*err) >>> GAIN_SHIFT, and the err_prev register and KD multiplier are not synthesised; all other behaviour is identical.

Verification
REQ-036 Reset, then upd with line_valid and centroid 320 -> TRACK; duty 600/600 after the next wrap.
REQ-037 Centroid 420 (from IDLE), then 470 -> 700/500, then 775/425 with STEER_DERIV_EN, or 750/450 without it.
REQ-038 KP=8, centroid 639 -> duty_l=1000 (pwm_l constant high), duty_r=0 (pwm_r constant low).
REQ-039 From TRACK with err>0, 30 consecutive line_lost updates -> SEARCH at 400/0, STOP on the 30th update at 0/0; one line_valid update -> TRACK.
REQ-040 Both flags in one update -> SEARCH; neither flag -> no change; target change mid-period -> pwm edges unchanged until the wrap.
REQ-041 Reset asserted at count 500 with duty 700 -> pwm_l low immediately; all outputs 0; state IDLE.
